// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU operations,
// data-processing command codes, condition codes and the registered control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH,
    BLINK
  } state_t;

  // ALUControl encodings (3-bit master form, truncated at the top level)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  // Data-processing cmd field Instr[24:21]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Instruction class Instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Condition codes Instr[31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Raw (ungated) control word held alongside the state register
  typedef struct packed {
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] ressrc;
    logic [2:0] aluc;
    logic       adrsrc;
    logic       irwrite;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       link;
  } ctl_t;

endpackage

// File: rtl/multicycle_ctrl_v2_cond_unit.sv
// Condition evaluation and the architectural NZCV flags register.
module cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cond,
  input  logic [3:0] aluflags,
  input  logic       flag_en,
  input  logic       cv_en,
  output logic       condex
);

  logic [3:0] flags;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags;

  // Evaluate the instruction's condition against the current flags
  always_comb begin
    condex = 1'b0;
    case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~(c & ~z);
      COND_GE: condex = (n == v);
      COND_LT: condex = (n != v);
      COND_GT: condex = ~z & (n == v);
      COND_LE: condex = z | (n != v);
      COND_AL: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  // Latch NZ on every enabled flag-setting op; CV only for arithmetic ops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
    end else if (flag_en && condex) begin
      flags[3:2] <= aluflags[3:2];
      if (cv_en) flags[1:0] <= aluflags[1:0];
    end
  end

endmodule

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle ARM-subset controller: FSM, instruction decode and
// condition-gated datapath strobes.
module multicycle_ctrl_v2
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUC_W = 3,
  parameter int unsigned HAS_BL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [19:0]       Instr,
  input  logic [3:0]        ALUFlags,
  output logic              PCWrite,
  output logic              MemWrite,
  output logic              RegWrite,
  output logic              IRWrite,
  output logic              AdrSrc,
  output logic [1:0]        RegSrc,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ImmSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              LinkWr
);

  state_t     state, nxt;
  ctl_t       ctl;
  logic       condex;
  logic [3:0] cond, cmd;
  logic [1:0] op;
  logic       ibit, sbit, lbit;
  logic [2:0] dp_alu;
  logic       dp_ok, dp_nowrite, dp_forced_s, dp_cv;
  logic       flag_en;
  logic       unused_instr;

  // Instr carries bits [31:12]; field offsets are shifted down by 12
  assign cond = Instr[19:16];
  assign op   = Instr[15:14];
  assign ibit = Instr[13];
  assign lbit = Instr[12];
  assign cmd  = Instr[12:9];
  assign sbit = Instr[8];
  assign unused_instr = ^Instr[7:0];

  // Decode the data-processing command into ALU op and write/flag policy
  always_comb begin
    dp_alu      = ALU_ADD;
    dp_ok       = 1'b1;
    dp_nowrite  = 1'b0;
    dp_forced_s = 1'b0;
    dp_cv       = 1'b0;
    case (cmd)
      CMD_ADD: begin dp_alu = ALU_ADD; dp_cv = 1'b1; end
      CMD_SUB: begin dp_alu = ALU_SUB; dp_cv = 1'b1; end
      CMD_AND: dp_alu = ALU_AND;
      CMD_ORR: dp_alu = ALU_ORR;
      CMD_CMP: begin
        dp_alu = ALU_SUB; dp_nowrite = 1'b1; dp_forced_s = 1'b1; dp_cv = 1'b1;
      end
      CMD_EOR: begin
        if (ALUC_W >= 3) dp_alu = ALU_EOR;
        else begin dp_ok = 1'b0; dp_nowrite = 1'b1; end
      end
      CMD_TST: begin
        if (ALUC_W >= 3) begin
          dp_alu = ALU_AND; dp_nowrite = 1'b1; dp_forced_s = 1'b1;
        end else begin
          dp_ok = 1'b0; dp_nowrite = 1'b1;
        end
      end
      default: begin dp_ok = 1'b0; dp_nowrite = 1'b1; end
    endcase
  end

  assign flag_en = ((state == EXECUTER) || (state == EXECUTEI)) && dp_ok &&
                   (sbit || dp_forced_s);

  cond_unit u_cond (
    .clk      (clk),
    .rst      (reset),
    .cond     (cond),
    .aluflags (ALUFlags),
    .flag_en  (flag_en),
    .cv_en    (dp_cv),
    .condex   (condex)
  );

  // Next-state selection
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:    nxt = DECODE;
      DECODE: begin
        case (op)
          OP_MEM:  nxt = MEMADR;
          OP_DP:   nxt = ibit ? EXECUTEI : EXECUTER;
          OP_BR:   nxt = ((HAS_BL != 0) && lbit) ? BLINK : BRANCH;
          default: nxt = FETCH;
        endcase
      end
      MEMADR:   nxt = sbit ? MEMREAD : MEMWRITE;
      MEMREAD:  nxt = MEMWB;
      EXECUTER: nxt = ALUWB;
      EXECUTEI: nxt = ALUWB;
      BLINK:    nxt = BRANCH;
      default:  nxt = FETCH;
    endcase
  end

  function automatic ctl_t ctl_for(input state_t s, input logic [2:0] alu,
                                   input logic nowrite);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite = 1'b1; c.nextpc = 1'b1;
        c.srca = 2'b01; c.srcb = 2'b10; c.ressrc = 2'b10; c.aluc = ALU_ADD;
      end
      DECODE: begin
        c.srca = 2'b01; c.srcb = 2'b10; c.ressrc = 2'b10; c.aluc = ALU_ADD;
      end
      MEMADR:   begin c.srca = 2'b00; c.srcb = 2'b01; c.aluc = ALU_ADD; end
      MEMREAD:  begin c.adrsrc = 1'b1; c.ressrc = 2'b00; end
      MEMWB:    begin c.ressrc = 2'b01; c.regw = 1'b1; end
      MEMWRITE: begin c.adrsrc = 1'b1; c.memw = 1'b1; end
      EXECUTER: begin c.srca = 2'b00; c.srcb = 2'b00; c.aluc = alu; end
      EXECUTEI: begin c.srca = 2'b00; c.srcb = 2'b01; c.aluc = alu; end
      ALUWB:    begin c.ressrc = 2'b00; c.regw = ~nowrite; end
      BLINK: begin
        c.srca = 2'b01; c.srcb = 2'b11; c.ressrc = 2'b10;
        c.link = 1'b1; c.regw = 1'b1;
      end
      BRANCH: begin
        c.srca = 2'b10; c.srcb = 2'b01; c.ressrc = 2'b10;
        c.aluc = ALU_ADD; c.branch = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // State register; the raw control word is registered for the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      ctl   <= ctl_for(FETCH, ALU_ADD, 1'b0);
    end else begin
      state <= nxt;
      ctl   <= ctl_for(nxt, dp_alu, dp_nowrite);
    end
  end

  // Gate write strobes by the condition and hold everything low during reset
  always_comb begin
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    RegSrc     = '0;
    ALUSrcA    = '0;
    ALUSrcB    = '0;
    ResultSrc  = '0;
    ImmSrc     = '0;
    ALUControl = '0;
    LinkWr     = 1'b0;
    if (!reset) begin
      PCWrite    = ctl.nextpc | (ctl.branch & condex);
      MemWrite   = ctl.memw & condex;
      RegWrite   = ctl.regw & condex;
      LinkWr     = ctl.link & condex;
      IRWrite    = ctl.irwrite;
      AdrSrc     = ctl.adrsrc;
      RegSrc     = {(op == OP_MEM) & ~sbit, (op == OP_BR)};
      ALUSrcA    = ctl.srca;
      ALUSrcB    = ctl.srcb;
      ResultSrc  = ctl.ressrc;
      ImmSrc     = op;
      ALUControl = ALUC_W'(ctl.aluc);
    end
  end

endmodule
